// File: rtl/mm_row_scheduler.sv
// Row-at-a-time scheduler for an [M x O] matrix multiply: issues O dot products per
// C row, gathers the in-order results into a row buffer and hands the row to a sink.
module mm_row_scheduler #(
    parameter int BATCH_SIZE          = 8,
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int OUTPUT_WIDTH        = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic [LOG_BATCH_SIZE-1:0]                 inputAddr,
    output logic [LOG_OUTPUT_FEATURES-1:0]            weightAddr,
    output logic                                      dpValid,
    input  logic [OUTPUT_WIDTH-1:0]                   dpResult,
    input  logic                                      dpResultValid,
    output logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0]   outputData,
    output logic [LOG_BATCH_SIZE-1:0]                 outputAddr,
    output logic                                      outputWrEn,
    input  logic                                      outputWrReady,
    output logic                                      overflowErr
);

    localparam int CNT_W = LOG_OUTPUT_FEATURES + 1;
    localparam logic [LOG_BATCH_SIZE-1:0]      LAST_ROW = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
    localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_COL = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);
    localparam logic [CNT_W-1:0]               FULL_CNT = CNT_W'(OUTPUT_FEATURES);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    state_t                                       state_q, state_d;
    logic [LOG_BATCH_SIZE-1:0]                    row_q, row_d;
    logic [LOG_OUTPUT_FEATURES-1:0]               col_q, col_d;
    logic [CNT_W-1:0]                             res_cnt_q, res_cnt_d;
    logic                                         overflow_q, overflow_d;
    logic [OUTPUT_FEATURES-1:0][OUTPUT_WIDTH-1:0] row_buf_q, row_buf_d;
    logic                                         slot_free;

    // Results are only expected while the current row still has empty slots.
    assign slot_free = ((state_q == ISSUE) || (state_q == DRAIN)) && (res_cnt_q < FULL_CNT);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        res_cnt_d  = res_cnt_q;
        overflow_d = overflow_q;
        row_buf_d  = row_buf_q;

        if (dpResultValid) begin
            if (slot_free) begin
                row_buf_d[res_cnt_q[LOG_OUTPUT_FEATURES-1:0]] = dpResult;
                res_cnt_d = res_cnt_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d      = '0;
                    col_d      = '0;
                    res_cnt_d  = '0;
                    overflow_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                // col parks on the last column so the weight address holds through DRAIN/WRITE
                if (col_q == LAST_COL) begin
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN: begin
                if (res_cnt_q == FULL_CNT) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (outputWrReady) begin
                    if (row_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        row_d     = row_q + 1'b1;
                        col_d     = '0;
                        res_cnt_d = '0;
                        state_d   = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            res_cnt_q  <= '0;
            overflow_q <= 1'b0;
            row_buf_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            res_cnt_q  <= res_cnt_d;
            overflow_q <= overflow_d;
            row_buf_q  <= row_buf_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign dpValid     = (state_q == ISSUE);
    assign outputWrEn  = (state_q == WRITE);
    assign inputAddr   = row_q;
    assign weightAddr  = col_q;
    assign outputAddr  = row_q;
    assign outputData  = row_buf_q;
    assign overflowErr = overflow_q;

endmodule

// File: tb/tb_mm_row_scheduler.sv
// Bench for mm_row_scheduler: a fixed-latency datapath model returns entries of a
// reference C matrix; each task runs one scenario and checks writes, timing and flags.
`timescale 1ns/1ps
module tb_mm_row_scheduler;

    localparam int M = 8;
    localparam int O = 8;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, dpValid, outputWrEn, overflowErr;
    logic [2:0]     inputAddr, weightAddr, outputAddr;
    logic [W-1:0]   dpResult = '0;
    logic           dpResultValid = 1'b0;
    logic           outputWrReady = 1'b1;
    logic [O*W-1:0] outputData;

    mm_row_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .inputAddr(inputAddr), .weightAddr(weightAddr), .dpValid(dpValid),
        .dpResult(dpResult), .dpResultValid(dpResultValid), .outputData(outputData),
        .outputAddr(outputAddr), .outputWrEn(outputWrEn), .outputWrReady(outputWrReady),
        .overflowErr(overflowErr)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [W-1:0] val; } pend_t;
    typedef struct { int cyc; logic [2:0] addr; logic [O*W-1:0] data; } wr_t;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int lat = 2;
    logic [W-1:0] cmat [M][O];
    pend_t pend[$];
    wr_t   wr_q[$];
    int    issue_start_q[$];
    pend_t np;
    wr_t   nw;
    int done_cnt = 0, both_hi_cnt = 0, unstable_cnt = 0, addr_move_cnt = 0, stall_seen = 0;
    int stall_row = -1, stall_left = 0;
    bit inject_req = 0, injected = 0;
    logic prev_dp = 0, prev_we = 0, prev_ready = 1;
    logic [2:0] prev_ia = 0, prev_wa = 0, prev_oa = 0;
    logic [O*W-1:0] prev_data = '0;

    // Datapath model, write sink and event recorder, all acting just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (dpValid === 1'b1) begin
            if (!prev_dp) issue_start_q.push_back(cyc);
            np.due = cyc + lat;
            np.val = cmat[inputAddr][weightAddr];
            pend.push_back(np);
        end
        dpResultValid = 1'b0;
        dpResult      = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            dpResultValid = 1'b1;
            dpResult      = pend[0].val;
            void'(pend.pop_front());
        end else if (inject_req && busy && !dpValid && !outputWrEn && pend.size() == 0) begin
            dpResultValid = 1'b1;
            dpResult      = 16'hDEAD;
            inject_req    = 0;
            injected      = 1;
        end
        outputWrReady = 1'b1;
        if (outputWrEn === 1'b1 && int'(outputAddr) == stall_row && stall_left > 0) begin
            outputWrReady = 1'b0;
            stall_left--;
        end
        if (outputWrEn === 1'b1 && outputWrReady) begin
            nw.cyc  = cyc;
            nw.addr = outputAddr;
            nw.data = outputData;
            wr_q.push_back(nw);
        end
        if (outputWrEn === 1'b1 && int'(outputAddr) == stall_row) stall_seen++;
        if (prev_we && !prev_ready && (outputWrEn !== 1'b1 || outputData !== prev_data || outputAddr !== prev_oa))
            unstable_cnt++;
        if (done === 1'b1) done_cnt++;
        if (dpValid === 1'b1 && outputWrEn === 1'b1) both_hi_cnt++;
        if (rst && dpValid === 1'b0 && outputWrEn === 1'b0 &&
            (inputAddr !== prev_ia || weightAddr !== prev_wa || outputAddr !== prev_oa))
            addr_move_cnt++;
        prev_dp    = (dpValid === 1'b1);
        prev_we    = (outputWrEn === 1'b1);
        prev_ready = outputWrReady;
        prev_ia    = inputAddr;
        prev_wa    = weightAddr;
        prev_oa    = outputAddr;
        prev_data  = outputData;
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_records();
        wr_q.delete();
        issue_start_q.delete();
        done_cnt = 0; both_hi_cnt = 0; unstable_cnt = 0; addr_move_cnt = 0; stall_seen = 0;
    endtask

    task automatic fill_random();
        for (int r = 0; r < M; r++)
            for (int k = 0; k < O; k++)
                cmat[r][k] = W'($urandom_range(0, 65535));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    function automatic logic [O*W-1:0] exp_row(input int r);
        logic [O*W-1:0] v;
        for (int k = 0; k < O; k++) v[k*W +: W] = cmat[r][k];
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({busy, done, dpValid, outputWrEn, overflowErr} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: busy/done/dpValid/wrEn/ovf got %b, expected 00000",
                     {busy, done, dpValid, outputWrEn, overflowErr});
        end
        tests_run++;
        if ({inputAddr, weightAddr, outputAddr} !== 9'b0 || outputData !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_addr_data: addrs %h data %h, expected all 0",
                     {inputAddr, weightAddr, outputAddr}, outputData);
        end
        start = 1'b0;
        rst = 1'b1;
        tick();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_priority: busy got %b, expected 0", busy);
        end
    endtask

    task automatic test_full_job();
        bit ok;
        lat = 2;
        for (int r = 0; r < M; r++)
            for (int k = 0; k < O; k++)
                cmat[r][k] = W'(r * 16 + k);
        clear_records();
        pulse_start();
        wait_done(400, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL full_done: no done pulse within 400 cycles");
        end
        tests_run++;
        if (wr_q.size() != M) begin
            tests_failed++;
            $display("[TB] FAIL full_write_count: got %0d, expected %0d", wr_q.size(), M);
        end
        foreach (wr_q[i]) begin
            tests_run++;
            if (wr_q[i].addr !== 3'(i) || wr_q[i].data !== exp_row(i)) begin
                tests_failed++;
                $display("[TB] FAIL full_row%0d: addr %0d data %h, expected addr %0d data %h",
                         i, wr_q[i].addr, wr_q[i].data, i, exp_row(i));
            end
            if (i < issue_start_q.size()) begin
                tests_run++;
                if (wr_q[i].cyc - issue_start_q[i] != O + lat + 1) begin
                    tests_failed++;
                    $display("[TB] FAIL full_row_time%0d: got %0d cycles, expected %0d",
                             i, wr_q[i].cyc - issue_start_q[i], O + lat + 1);
                end
            end
            if (i + 1 < issue_start_q.size()) begin
                tests_run++;
                if (issue_start_q[i+1] - wr_q[i].cyc != 1) begin
                    tests_failed++;
                    $display("[TB] FAIL full_reissue%0d: got %0d cycles, expected 1",
                             i, issue_start_q[i+1] - wr_q[i].cyc);
                end
            end
        end
        tick();
        tick();
        tests_run++;
        if (done_cnt != 1 || done !== 1'b0 || busy !== 1'b0 || overflowErr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_end: done pulses %0d done %b busy %b ovf %b, expected 1 0 0 0",
                     done_cnt, done, busy, overflowErr);
        end
        tests_run++;
        if (outputData !== exp_row(M - 1) || both_hi_cnt != 0 || addr_move_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL full_hold: data %h overlap %0d addr moves %0d, expected %h 0 0",
                     outputData, both_hi_cnt, addr_move_cnt, exp_row(M - 1));
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        lat = int'($urandom_range(1, 3));
        fill_random();
        clear_records();
        stall_row = 3;
        stall_left = 5;
        pulse_start();
        wait_done(500, ok);
        tests_run++;
        if (!ok || wr_q.size() != M) begin
            tests_failed++;
            $display("[TB] FAIL bp_complete: done %b writes %0d, expected 1 %0d", ok, wr_q.size(), M);
        end
        foreach (wr_q[i]) begin
            tests_run++;
            if (wr_q[i].addr !== 3'(i) || wr_q[i].data !== exp_row(i)) begin
                tests_failed++;
                $display("[TB] FAIL bp_row%0d: addr %0d data %h, expected addr %0d data %h",
                         i, wr_q[i].addr, wr_q[i].data, i, exp_row(i));
            end
        end
        tests_run++;
        if (stall_seen != 6 || unstable_cnt != 0 || both_hi_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: wrEn cycles on row 3 %0d unstable %0d overlap %0d, expected 6 0 0",
                     stall_seen, unstable_cnt, both_hi_cnt);
        end
        if (wr_q.size() > 3 && issue_start_q.size() > 4) begin
            tests_run++;
            if (wr_q[3].cyc - issue_start_q[3] != O + lat + 6 || issue_start_q[4] - wr_q[3].cyc != 1) begin
                tests_failed++;
                $display("[TB] FAIL bp_timing: row3 %0d cycles, row4 issue gap %0d, expected %0d and 1",
                         wr_q[3].cyc - issue_start_q[3], issue_start_q[4] - wr_q[3].cyc, O + lat + 6);
            end
        end
        stall_row = -1;
        tick();
    endtask

    task automatic test_latency();
        int lats [2] = '{0, 4};
        int exp_t [2] = '{9, 13};
        bit ok;
        for (int t = 0; t < 2; t++) begin
            lat = lats[t];
            fill_random();
            clear_records();
            pulse_start();
            wait_done(500, ok);
            tests_run++;
            if (!ok || wr_q.size() != M || issue_start_q.size() != M) begin
                tests_failed++;
                $display("[TB] FAIL lat%0d_complete: done %b writes %0d issue runs %0d, expected 1 %0d %0d",
                         lat, ok, wr_q.size(), issue_start_q.size(), M, M);
            end
            foreach (wr_q[i]) begin
                tests_run++;
                if (wr_q[i].addr !== 3'(i) || wr_q[i].data !== exp_row(i)) begin
                    tests_failed++;
                    $display("[TB] FAIL lat%0d_row%0d: addr %0d data %h, expected addr %0d data %h",
                             lat, i, wr_q[i].addr, wr_q[i].data, i, exp_row(i));
                end
                if (i < issue_start_q.size()) begin
                    tests_run++;
                    if (wr_q[i].cyc - issue_start_q[i] != exp_t[t]) begin
                        tests_failed++;
                        $display("[TB] FAIL lat%0d_time%0d: got %0d cycles, expected %0d",
                                 lat, i, wr_q[i].cyc - issue_start_q[i], exp_t[t]);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_spurious();
        bit ok;
        lat = 2;
        fill_random();
        clear_records();
        injected = 0;
        inject_req = 1;
        pulse_start();
        wait_done(500, ok);
        tests_run++;
        if (!ok || !injected || overflowErr !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL spur_flag: done %b injected %b ovf %b, expected 1 1 1", ok, injected, overflowErr);
        end
        foreach (wr_q[i]) begin
            tests_run++;
            if (wr_q[i].data !== exp_row(i)) begin
                tests_failed++;
                $display("[TB] FAIL spur_row%0d: data %h, expected %h", i, wr_q[i].data, exp_row(i));
            end
        end
        repeat (3) tick();
        tests_run++;
        if (overflowErr !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL spur_sticky: ovf %b, expected 1", overflowErr);
        end
        clear_records();
        pulse_start();
        tests_run++;
        if (overflowErr !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL spur_clear: ovf %b busy %b, expected 0 1", overflowErr, busy);
        end
        wait_done(500, ok);
        tests_run++;
        if (!ok || overflowErr !== 1'b0 || wr_q.size() != M) begin
            tests_failed++;
            $display("[TB] FAIL spur_rerun: done %b ovf %b writes %0d, expected 1 0 %0d",
                     ok, overflowErr, wr_q.size(), M);
        end
        tick();
    endtask

    task automatic test_reset_mid_job();
        bit ok, found;
        lat = 2;
        fill_random();
        clear_records();
        pulse_start();
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (dpValid === 1'b1 && inputAddr === 3'd2 && weightAddr === 3'd5) found = 1;
            else tick();
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_reach: row 2 col 5 issue not seen within 300 cycles");
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tests_run++;
        if ({busy, done, dpValid, outputWrEn, overflowErr} !== 5'b0 ||
            {inputAddr, weightAddr, outputAddr} !== 9'b0 || outputData !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_outputs: flags %b addrs %h data %h, expected all 0",
                     {busy, done, dpValid, outputWrEn, overflowErr}, {inputAddr, weightAddr, outputAddr}, outputData);
        end
        repeat (4) tick();
        tests_run++;
        if (overflowErr !== 1'b1 || pend.size() != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_late: ovf %b pending %0d busy %b, expected 1 0 0",
                     overflowErr, pend.size(), busy);
        end
        fill_random();
        clear_records();
        pulse_start();
        wait_done(500, ok);
        tests_run++;
        if (!ok || overflowErr !== 1'b0 || wr_q.size() != M) begin
            tests_failed++;
            $display("[TB] FAIL rst_mid_rerun: done %b ovf %b writes %0d, expected 1 0 %0d",
                     ok, overflowErr, wr_q.size(), M);
        end
        foreach (wr_q[i]) begin
            tests_run++;
            if (wr_q[i].addr !== 3'(i) || wr_q[i].data !== exp_row(i)) begin
                tests_failed++;
                $display("[TB] FAIL rst_mid_row%0d: addr %0d data %h, expected addr %0d data %h",
                         i, wr_q[i].addr, wr_q[i].data, i, exp_row(i));
            end
        end
        tick();
    endtask

    task automatic test_start_held();
        bit ok;
        lat = 1;
        fill_random();
        clear_records();
        start = 1'b1;
        tick();
        wait_done(500, ok);
        tests_run++;
        if (!ok || wr_q.size() != M || done_cnt != 1) begin
            tests_failed++;
            $display("[TB] FAIL held_first: done %b writes %0d pulses %0d, expected 1 %0d 1",
                     ok, wr_q.size(), done_cnt, M);
        end
        foreach (wr_q[i]) begin
            tests_run++;
            if (wr_q[i].addr !== 3'(i)) begin
                tests_failed++;
                $display("[TB] FAIL held_order%0d: addr %0d, expected %0d", i, wr_q[i].addr, i);
            end
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL held_idle: busy %b done %b, expected 0 0", busy, done);
        end
        tick();
        start = 1'b0;
        tests_run++;
        if (dpValid !== 1'b1 || inputAddr !== 3'd0 || weightAddr !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL held_restart: dpValid %b row %0d col %0d, expected 1 0 0",
                     dpValid, inputAddr, weightAddr);
        end
        wait_done(500, ok);
        tests_run++;
        if (!ok || wr_q.size() != 2 * M || done_cnt != 2) begin
            tests_failed++;
            $display("[TB] FAIL held_second: done %b writes %0d pulses %0d, expected 1 %0d 2",
                     ok, wr_q.size(), done_cnt, 2 * M);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_job();
        test_backpressure();
        test_latency();
        test_spurious();
        test_reset_mid_job();
        test_start_held();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mm_row_scheduler.md
MM_ROW_SCHEDULER -- requirements
Module: mm_row_scheduler

Interface
REQ-001 SHALL have parameter BATCH_SIZE, default 8, meaning M, the number of rows of A and of C.
REQ-002 SHALL have parameter LOG_BATCH_SIZE, default 3, meaning the row-index width.
REQ-003 SHALL have parameter OUTPUT_FEATURES, default 8, meaning O, the number of rows of B-transpose and of C columns.
REQ-004 SHALL have parameter LOG_OUTPUT_FEATURES, default 3, meaning the column-index width.
REQ-005 SHALL have parameter OUTPUT_WIDTH, default 16, meaning the width of one dot-product result.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: request one full [M x O] multiply.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a job.
REQ-011 SHALL have port inputAddr, output, LOG_BATCH_SIZE bits: the A row being fetched.
REQ-012 SHALL have port weightAddr, output, LOG_OUTPUT_FEATURES bits: the B-transpose row being fetched.
REQ-013 SHALL have port dpValid, output, 1 bit: issue one dot product this cycle using inputAddr and weightAddr.
REQ-014 SHALL have port dpResult, input, OUTPUT_WIDTH bits: dot-product result, returned in issue order.
REQ-015 SHALL have port dpResultValid, input, 1 bit: dpResult is valid this cycle.
REQ-016 SHALL have port outputData, output, OUTPUT_FEATURES*OUTPUT_WIDTH bits: the C row buffer; slot k occupies bits [k*OUTPUT_WIDTH +: OUTPUT_WIDTH].
REQ-017 SHALL have port outputAddr, output, LOG_BATCH_SIZE bits: the C row being written.
REQ-018 SHALL have port outputWrEn, output, 1 bit: outputData and outputAddr are valid for writing.
REQ-019 SHALL have port outputWrReady, input, 1 bit: the sink accepts the write this cycle.
REQ-020 SHALL have port overflowErr, output, 1 bit: sticky flag for an unexpected result.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, DRAIN, WRITE and DONE; all outputs SHALL be decoded from registered state (Moore).
REQ-022 In IDLE, start=1 SHALL clear row, col, resCnt and overflowErr, then enter ISSUE; start SHALL be ignored in all other states.
REQ-023 ISSUE behaviour:
- dpValid=1, inputAddr=row, weightAddr=col.
- col increments each cycle.
- When col==O-1, the FSM SHALL enter DRAIN on the next edge.
REQ-024 Exactly O issues SHALL occur per row, on consecutive cycles.
REQ-025 In ISSUE or DRAIN, dpResultValid with resCnt<O SHALL write dpResult into slot resCnt and increment resCnt; a result arriving on the ISSUE-to-DRAIN edge SHALL be counted.
REQ-026 DRAIN SHALL wait until resCnt==O, then enter WRITE; the last result SHALL be in outputData on the first WRITE cycle.
REQ-027 dpResultValid with resCnt==O, or in IDLE, WRITE or DONE, SHALL be ignored and SHALL set overflowErr; overflowErr clears only on an accepted start or on reset.
REQ-028 WRITE handshake:
- outputWrEn=1, outputAddr=row; outputData held stable until the handshake completes.
- Transfer occurs on a cycle with outputWrEn=1 and outputWrReady=1.
REQ-029 On a transfer with row<M-1: row increments, col and resCnt clear, and the FSM enters ISSUE; on a transfer with row==M-1, the FSM enters DONE.
REQ-030 DONE SHALL assert done=1 for exactly one cycle, then enter IDLE; outputData SHALL retain the last row.
REQ-031 The row and col counters SHALL be LOG widths and SHALL never wrap within a job.
REQ-032 With datapath latency L and an always-ready sink, each row SHALL take O+L+1 cycles from the first issue to the transfer, plus 1 cycle to re-enter ISSUE.
REQ-033 dpValid and outputWrEn SHALL never be high in the same cycle.
REQ-034 When dpValid=0 and outputWrEn=0, inputAddr, weightAddr and outputAddr SHALL hold their last values.

Reset
REQ-035 rst=0 at a rising edge SHALL force IDLE from any state, including mid-ISSUE, DRAIN or WRITE.
REQ-036 Reset SHALL set all outputs, counters and the row buffer to 0; busy, done, dpValid, outputWrEn and overflowErr SHALL all be 0.
REQ-037 Results from in-flight dot products that arrive after reset (the FSM is then in IDLE) SHALL be ignored and SHALL set overflowErr.
REQ-038 rst SHALL take priority over start in the same cycle.

Verification
REQ-039 Full job: M=8, O=8, datapath latency 2, result=row*16+col, sink always ready, pulse start -> 8 writes with outputAddr 0..7; slot k of row r = r*16+k; one done pulse; overflowErr=0.
REQ-040 Backpressure: outputWrReady=0 for 5 cycles on row 3 -> outputWrEn held; outputData and outputAddr=3 stable; no dpValid until the transfer; row 4 issues afterwards.
REQ-041 Latency: datapath latency 0, then 4 -> per-row ISSUE-start to transfer takes 9 and 13 cycles respectively; data correct in both cases.
REQ-042 Spurious result: inject a 9th dpResultValid in DRAIN of row 0 -> overflowErr=1 and stays high; buffer unchanged; the next start clears it.
REQ-043 Reset mid-job: rst=0 in ISSUE of row 2, col 5 -> next cycle IDLE, all outputs 0; 2 late results -> overflowErr=1; a new start runs cleanly from row 0.
REQ-044 start held high through a job -> start ignored while busy; a second job begins on the cycle after done.
